// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a single-clock, non-showahead FIFO (empty/rdreq/q) and presents its
// contents as a valid/ready stream. Reads are issued only when there is a
// guaranteed slot in the local skid buffer for the word once it emerges from
// the FIFO's fixed read latency, so sink backpressure never loses or
// duplicates a word.
//
// Parameters
//   DWIDTH      data word width
//   RD_LATENCY  cycles from fifo_rdreq_o to valid fifo_q_i (1 or 2)
//   BUF_DEPTH   skid buffer depth, at least RD_LATENCY+1
//
// Ports
//   clk_i         clock
//   arst_n_i      asynchronous active-low reset
//   fifo_empty_i  FIFO empty flag
//   fifo_q_i      FIFO read data
//   fifo_rdreq_o  FIFO read request (combinational, gated by reset)
//   src_data_o    stream data, head of the skid buffer (registered)
//   src_valid_o   stream valid (registered)
//   src_ready_i   stream ready
//   words_o       completed stream handshakes, wraps modulo 2^32
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DWIDTH     = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic [31:0]       words_o
);

    // Credit arithmetic must hold occ + infl without overflow.
    localparam int CW = $clog2(BUF_DEPTH + RD_LATENCY) + 1;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    // Number of reads currently travelling through the FIFO read pipeline.
    function automatic logic [CW-1:0] count_ones(input logic [RD_LATENCY-1:0] vec);
        logic [CW-1:0] acc;
        acc = {CW{1'b0}};
        for (int i = 0; i < RD_LATENCY; i++) begin
            acc = acc + {{(CW-1){1'b0}}, vec[i]};
        end
        return acc;
    endfunction

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        logic [PW-1:0] res;
        if (ptr == PW'(BUF_DEPTH - 1)) begin
            res = {PW{1'b0}};
        end else begin
            res = ptr + {{(PW-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [DWIDTH-1:0]     mem_r [BUF_DEPTH];
    logic [DWIDTH-1:0]     mem_nxt_s [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         wr_ptr_nxt_s;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         rd_ptr_nxt_s;
    logic [CW-1:0]         occ_r;
    logic [CW-1:0]         occ_nxt_s;
    logic [RD_LATENCY-1:0] infl_r;
    logic [RD_LATENCY-1:0] infl_nxt_s;
    logic [DWIDTH-1:0]     head_r;
    logic [DWIDTH-1:0]     head_nxt_s;
    logic                  valid_r;
    logic                  valid_nxt_s;
    logic [31:0]           words_r;
    logic [31:0]           words_nxt_s;
    logic [CW-1:0]         credit_s;
    logic                  rdreq_s;
    logic                  pop_s;
    logic                  wr_s;

    // Handshake and landing of a read that has completed its latency.
    always_comb begin
        pop_s = valid_r & src_ready_i;
        wr_s  = infl_r[RD_LATENCY-1];
    end

    // Read issue: a pop this cycle frees a slot immediately, which is what
    // lets the reader run at one word per cycle and resume without a bubble.
    always_comb begin
        credit_s = occ_r + count_ones(infl_r) - {{(CW-1){1'b0}}, pop_s};
        if (!arst_n_i) begin
            rdreq_s = 1'b0;
        end else if (fifo_empty_i) begin
            rdreq_s = 1'b0;
        end else if (credit_s < CW'(BUF_DEPTH)) begin
            rdreq_s = 1'b1;
        end else begin
            rdreq_s = 1'b0;
        end
    end

    // In-flight shift register: bit 0 is a read issued last cycle.
    always_comb begin
        infl_nxt_s    = {RD_LATENCY{1'b0}};
        infl_nxt_s[0] = rdreq_s;
        for (int i = 1; i < RD_LATENCY; i++) begin
            infl_nxt_s[i] = infl_r[i-1];
        end
    end

    // Skid buffer storage and pointers.
    always_comb begin
        mem_nxt_s = mem_r;
        if (wr_s) begin
            mem_nxt_s[wr_ptr_r] = fifo_q_i;
            wr_ptr_nxt_s        = next_ptr(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = next_ptr(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Occupancy: simultaneous write and pop leave it unchanged.
    always_comb begin
        case ({wr_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   occ_nxt_s = occ_r - {{(CW-1){1'b0}}, 1'b1};
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Registered stream outputs: the head is looked up from the next-state
    // buffer so a word written into an empty buffer is visible next cycle.
    always_comb begin
        head_nxt_s  = mem_nxt_s[rd_ptr_nxt_s];
        valid_nxt_s = (occ_nxt_s != {CW{1'b0}});
        if (pop_s) begin
            words_nxt_s = words_r + 32'd1;
        end else begin
            words_nxt_s = words_r;
        end
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= {DWIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {CW{1'b0}};
            infl_r   <= {RD_LATENCY{1'b0}};
            head_r   <= {DWIDTH{1'b0}};
            valid_r  <= 1'b0;
            words_r  <= 32'd0;
        end else begin
            mem_r    <= mem_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            occ_r    <= occ_nxt_s;
            infl_r   <= infl_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= valid_nxt_s;
            words_r  <= words_nxt_s;
        end
    end

    assign fifo_rdreq_o = rdreq_s;
    assign src_data_o   = head_r;
    assign src_valid_o  = valid_r;
    assign words_o      = words_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// Directed bench for fifo_stream_reader. Two instances share one stimulus:
// dut1 uses RD_LATENCY=1 / BUF_DEPTH=2, dut2 uses RD_LATENCY=2 / BUF_DEPTH=3.
// Each sits on its own behavioural FIFO model fed by the same writes.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        rdy;
    logic        wr;
    logic [7:0]  wd;

    logic        empty1 = 1'b1;
    logic        empty2 = 1'b1;
    logic [7:0]  q1  = 8'd0;
    logic [7:0]  q2a = 8'd0;
    logic [7:0]  q2  = 8'd0;
    logic [7:0]  fq1 [$];
    logic [7:0]  fq2 [$];

    logic        rdreq1, rdreq2, valid1, valid2;
    logic [7:0]  data1, data2;
    logic [31:0] words1, words2;

    int n_cmp = 0;
    int n_err = 0;
    int n1, n2, cnt, d1, d2, rem1, rem2, total;
    logic [7:0] exp1, exp2, wval;

    fifo_stream_reader #(.DWIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2)) dut1 (
        .clk_i(clk), .arst_n_i(arst_n), .fifo_empty_i(empty1), .fifo_q_i(q1),
        .fifo_rdreq_o(rdreq1), .src_data_o(data1), .src_valid_o(valid1),
        .src_ready_i(rdy), .words_o(words1)
    );

    fifo_stream_reader #(.DWIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(3)) dut2 (
        .clk_i(clk), .arst_n_i(arst_n), .fifo_empty_i(empty2), .fifo_q_i(q2),
        .fifo_rdreq_o(rdreq2), .src_data_o(data2), .src_valid_o(valid2),
        .src_ready_i(rdy), .words_o(words2)
    );

    // FIFO models: unregistered output (latency 1) and registered output (latency 2).
    always @(posedge clk) begin
        if (wr) begin
            fq1.push_back(wd);
            fq2.push_back(wd);
        end
        if (rdreq1) q1 <= fq1.pop_front();
        if (rdreq2) q2a <= fq2.pop_front();
        q2 <= q2a;
        empty1 <= (fq1.size() == 0);
        empty2 <= (fq2.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    initial begin
        arst_n = 1'b0;
        rdy    = 1'b1;
        wr     = 1'b0;
        wd     = 8'd0;

        // 1: reset values, FIFO non-empty while reset held
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); wr = 1'b1; wd = 8'(i);
        end
        @(negedge clk); wr = 1'b0; #1;
        chk("rst_rdreq1", 32'(rdreq1), 32'd0);
        chk("rst_rdreq2", 32'(rdreq2), 32'd0);
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_valid2", 32'(valid2), 32'd0);
        chk("rst_data1",  32'(data1),  32'd0);
        chk("rst_data2",  32'(data2),  32'd0);
        chk("rst_words1", words1, 32'd0);
        chk("rst_words2", words2, 32'd0);
        @(negedge clk); #1;
        chk("rst_hold_rdreq1", 32'(rdreq1), 32'd0);

        // 2/5: sustained drain, ready held high
        @(negedge clk); arst_n = 1'b1;
        for (int k = 0; k < 21; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("s2_rdreq1", 32'(rdreq1), 32'(k < 16));
            chk("s2_valid1", 32'(valid1), 32'(k >= 2 && k < 18));
            if (k >= 2 && k < 18) chk("s2_data1", 32'(data1), 32'(k - 2));
            chk("s5_rdreq2", 32'(rdreq2), 32'(k < 16));
            chk("s5_valid2", 32'(valid2), 32'(k >= 3 && k < 19));
            if (k >= 3 && k < 19) chk("s5_data2", 32'(data2), 32'(k - 3));
        end
        chk("s2_words1", words1, 32'd16);
        chk("s5_words2", words2, 32'd16);

        // 3: backpressure, 16 words 0x10..0x1F written with ready low
        rdy = 1'b0;
        n1 = 0; n2 = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            wr = (i < 16);
            wd = 8'(8'h10 + i);
            #1;
            n1 += int'(rdreq1);
            n2 += int'(rdreq2);
            if (i >= 10) begin
                chk("s3_hold_data1", 32'(data1), 32'h10);
                chk("s3_hold_data2", 32'(data2), 32'h10);
            end
        end
        wr = 1'b0;
        chk("s3_rdreqs1", 32'(n1), 32'd2);
        chk("s3_rdreqs2", 32'(n2), 32'd3);
        chk("s3_valid1", 32'(valid1), 32'd1);
        chk("s3_valid2", 32'(valid2), 32'd1);
        chk("s3_words1", words1, 32'd16);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); rdy = 1'b1; #1;
            if (c == 0) begin
                chk("s3_resume_rdreq1", 32'(rdreq1), 32'd1);
                chk("s3_resume_rdreq2", 32'(rdreq2), 32'd1);
            end
            chk("s3_valid1_run", 32'(valid1), 32'd1);
            chk("s3_data1_run",  32'(data1),  32'(8'h10 + c));
            chk("s3_valid2_run", 32'(valid2), 32'd1);
            chk("s3_data2_run",  32'(data2),  32'(8'h10 + c));
        end
        repeat (4) @(negedge clk);
        #1;
        chk("s3_words1_end", words1, 32'd32);
        chk("s3_words2_end", words2, 32'd32);
        chk("s3_idle_valid1", 32'(valid1), 32'd0);

        // 4: random ready and writes against a scoreboard, then drain
        exp1 = 8'h20; exp2 = 8'h20; wval = 8'h20; total = 32;
        for (int c = 0; c < 2030; c++) begin
            @(negedge clk);
            if (c < 2000) begin
                rdy = 1'($urandom_range(0, 1));
                wr  = ($urandom_range(0, 99) < 30);
            end else begin
                rdy = 1'b1;
                wr  = 1'b0;
            end
            wd = wval;
            if (wr) begin
                wval = wval + 8'd1;
                total++;
            end
            #1;
            chk("s4_underflow1", 32'(rdreq1 & empty1), 32'd0);
            chk("s4_underflow2", 32'(rdreq2 & empty2), 32'd0);
            chk("s4_occ1_ok", 32'(int'(dut1.occ_r) <= 2), 32'd1);
            chk("s4_occ2_ok", 32'(int'(dut2.occ_r) <= 3), 32'd1);
            if (valid1 && rdy) begin
                chk("s4_data1", 32'(data1), 32'(exp1));
                exp1 = exp1 + 8'd1;
            end
            if (valid2 && rdy) begin
                chk("s4_data2", 32'(data2), 32'(exp2));
                exp2 = exp2 + 8'd1;
            end
        end
        wr = 1'b0;
        chk("s4_all_delivered1", 32'(exp1), 32'(wval));
        chk("s4_all_delivered2", 32'(exp2), 32'(wval));
        chk("s4_words1", words1, 32'(total));
        chk("s4_words2", words2, 32'(total));

        // 6: reset mid-stream after 5 deliveries
        rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); wr = 1'b1; wd = wval; wval = wval + 8'd1;
        end
        @(negedge clk); wr = 1'b0;
        cnt = 0;
        for (int b = 0; b < 30; b++) begin
            if (b != 0) @(negedge clk);
            rdy = 1'b1; #1;
            if (valid1 && rdy) begin
                chk("s6_pre_data1", 32'(data1), 32'(exp1));
                exp1 = exp1 + 8'd1;
                cnt++;
            end
            if (cnt == 5) break;
        end
        chk("s6_five_delivered", 32'(cnt), 32'd5);
        @(posedge clk); #2;
        arst_n = 1'b0; #1;
        chk("s6_rst_rdreq1", 32'(rdreq1), 32'd0);
        chk("s6_rst_valid1", 32'(valid1), 32'd0);
        chk("s6_rst_data1",  32'(data1),  32'd0);
        chk("s6_rst_words1", words1, 32'd0);
        chk("s6_rst_valid2", 32'(valid2), 32'd0);
        chk("s6_rst_words2", words2, 32'd0);
        @(negedge clk); #1;
        chk("s6_hold_rdreq1", 32'(rdreq1), 32'd0);
        chk("s6_hold_rdreq2", 32'(rdreq2), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        exp1 = fq1[0]; rem1 = fq1.size();
        exp2 = fq2[0]; rem2 = fq2.size();
        #1;
        chk("s6_rel_words1", words1, 32'd0);
        chk("s6_rel_valid1", 32'(valid1), 32'd0);
        chk("s6_rel_valid2", 32'(valid2), 32'd0);
        d1 = 0; d2 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (valid1 && rdy) begin
                chk("s6_post_data1", 32'(data1), 32'(exp1));
                exp1 = exp1 + 8'd1;
                d1++;
            end
            if (valid2 && rdy) begin
                chk("s6_post_data2", 32'(data2), 32'(exp2));
                exp2 = exp2 + 8'd1;
                d2++;
            end
        end
        chk("s6_count1", 32'(d1), 32'(rem1));
        chk("s6_count2", 32'(d2), 32'(rem2));
        chk("s6_words1", words1, 32'(rem1));
        chk("s6_words2", words2, 32'(rem2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
